// File: rtl/video_stream_gen_pkg.sv
// Shared types and constants for the video stream generator.
package video_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LINE   = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAT_RAMP_X  = 2'd0,
        PAT_RAMP_XY = 2'd1,
        PAT_DELTA   = 2'd2,
        PAT_CONST   = 2'd3
    } pattern_t;

    // Sync levels while idle or in reset: both blanking flags high.
    localparam logic HS_RESET = 1'b1;
    localparam logic VS_RESET = 1'b1;

endpackage

// File: rtl/video_stream_gen_if.sv
// Pixel-stream bus (data, valid strobe, line/frame blanking flags).
interface video_stream_gen_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0] do_o;
    logic                   de_o;
    logic                   hs_o;
    logic                   vs_o;

    modport master (output do_o, de_o, hs_o, vs_o);
    modport slave  (input  do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/video_stream_gen_pattern.sv
// Combinational test-pattern lookup: pixel coordinate -> pixel value.
module video_pattern
    import video_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 13
) (
    input  logic [CNT_WIDTH-1:0]   x,
    input  logic [CNT_WIDTH-1:0]   y,
    input  pattern_t               pattern,
    input  logic [CNT_WIDTH-1:0]   pulse_x,
    input  logic [CNT_WIDTH-1:0]   pulse_y,
    input  logic [PIXEL_WIDTH-1:0] const_val,
    output logic [PIXEL_WIDTH-1:0] pixel
);

    logic [CNT_WIDTH-1:0] sum;

    // Select the pattern value; ramps wrap modulo the pixel width.
    always_comb begin
        sum   = x + y;
        pixel = '0;
        unique case (pattern)
            PAT_RAMP_X:  pixel = PIXEL_WIDTH'(x);
            PAT_RAMP_XY: pixel = PIXEL_WIDTH'(sum);
            PAT_DELTA:   pixel = (x == pulse_x && y == pulse_y) ? '1 : '0;
            PAT_CONST:   pixel = const_val;
        endcase
    end

endmodule

// File: rtl/video_stream_gen.sv
// Frame generator: line/blanking FSM, counters, shadow config and
// registered pixel-stream outputs.
module video_stream_gen
    import video_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH     = 8,
    parameter int CNT_WIDTH       = 13,
    parameter int PERIOD_WIDTH    = 4,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic [1:0]                 pattern_i,
    input  logic [CNT_WIDTH-1:0]       width_i,
    input  logic [CNT_WIDTH-1:0]       height_i,
    input  logic [PERIOD_WIDTH-1:0]    de_period_i,
    input  logic [CNT_WIDTH-1:0]       hblank_i,
    input  logic [CNT_WIDTH-1:0]       vblank_i,
    input  logic [CNT_WIDTH-1:0]       pulse_x_i,
    input  logic [CNT_WIDTH-1:0]       pulse_y_i,
    input  logic [PIXEL_WIDTH-1:0]     const_i,
    video_stream_gen_if.master         vid,
    output logic                       busy_o,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o
);

    localparam logic [CNT_WIDTH-1:0]       C_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]         B_ONE = (CNT_WIDTH+1)'(1);
    localparam logic [PERIOD_WIDTH-1:0]    P_ONE = PERIOD_WIDTH'(1);
    localparam logic [FRAME_CNT_WIDTH-1:0] F_ONE = FRAME_CNT_WIDTH'(1);

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]    x, y;
    logic [PERIOD_WIDTH-1:0] slot;
    logic [CNT_WIDTH:0]      blank_cnt;

    // Shadow config; period and hblank hold the already-clamped (>=1) values.
    pattern_t                cfg_pattern;
    logic [CNT_WIDTH-1:0]    cfg_width, cfg_height, cfg_hblank, cfg_vblank;
    logic [CNT_WIDTH-1:0]    cfg_pulse_x, cfg_pulse_y;
    logic [PERIOD_WIDTH-1:0] cfg_period;
    logic [PIXEL_WIDTH-1:0]  cfg_const;

    logic start_ok, capture, slot_last, line_last, frame_last;
    logic hblank_end, vblank_end;
    logic [PIXEL_WIDTH-1:0] pixel;

    video_pattern #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_pattern (
        .x         (x),
        .y         (y),
        .pattern   (cfg_pattern),
        .pulse_x   (cfg_pulse_x),
        .pulse_y   (cfg_pulse_y),
        .const_val (cfg_const),
        .pixel     (pixel)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic, end-of-interval flags and config capture strobe.
    always_comb begin
        state_nxt  = state;
        start_ok   = en_i && (width_i != '0) && (height_i != '0);
        slot_last  = (slot == cfg_period - P_ONE);
        line_last  = (x == cfg_width - C_ONE);
        frame_last = (y == cfg_height - C_ONE);
        hblank_end = (blank_cnt == {1'b0, cfg_hblank} - B_ONE);
        vblank_end = (blank_cnt == {1'b0, cfg_hblank} + {1'b0, cfg_vblank} - B_ONE);
        capture    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_LINE;
                    capture   = 1'b1;
                end
            end
            ST_LINE: begin
                if (slot_last && line_last)
                    state_nxt = frame_last ? ST_VBLANK : ST_HBLANK;
            end
            ST_HBLANK: begin
                if (hblank_end) state_nxt = ST_LINE;
            end
            ST_VBLANK: begin
                if (vblank_end) begin
                    state_nxt = start_ok ? ST_LINE : ST_IDLE;
                    capture   = start_ok;
                end
            end
        endcase
    end

    // Shadow config capture at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pattern <= PAT_RAMP_X;
            cfg_width   <= '0;
            cfg_height  <= '0;
            cfg_period  <= P_ONE;
            cfg_hblank  <= C_ONE;
            cfg_vblank  <= '0;
            cfg_pulse_x <= '0;
            cfg_pulse_y <= '0;
            cfg_const   <= '0;
        end else if (capture) begin
            cfg_pattern <= pattern_t'(pattern_i);
            cfg_width   <= width_i;
            cfg_height  <= height_i;
            cfg_period  <= (de_period_i == '0) ? P_ONE : de_period_i;
            cfg_hblank  <= (hblank_i == '0) ? C_ONE : hblank_i;
            cfg_vblank  <= vblank_i;
            cfg_pulse_x <= pulse_x_i;
            cfg_pulse_y <= pulse_y_i;
            cfg_const   <= const_i;
        end
    end

    // Slot, pixel, line and blanking counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            slot      <= '0;
            blank_cnt <= '0;
        end else begin
            if (state == ST_LINE) begin
                if (slot_last) begin
                    slot <= '0;
                    if (line_last) begin
                        x <= '0;
                        y <= frame_last ? '0 : y + C_ONE;
                    end else begin
                        x <= x + C_ONE;
                    end
                end else begin
                    slot <= slot + P_ONE;
                end
            end else begin
                slot <= '0;
            end
            // Blank counter runs only while staying in a blanking state.
            blank_cnt <= ((state == ST_HBLANK || state == ST_VBLANK) && state_nxt == state)
                         ? blank_cnt + B_ONE : '0;
        end
    end

    // Registered outputs derived from the current state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid.do_o    <= '0;
            vid.de_o    <= 1'b0;
            vid.hs_o    <= HS_RESET;
            vid.vs_o    <= VS_RESET;
            busy_o      <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            vid.de_o <= (state == ST_LINE) && slot_last;
            if (state == ST_LINE && slot_last) vid.do_o <= pixel;
            vid.hs_o <= (state != ST_LINE);
            vid.vs_o <= (state == ST_IDLE) || (state == ST_VBLANK);
            busy_o   <= (state != ST_IDLE);
            // First VBLANK cycle: count the frame alongside the rising vs_o.
            if (state == ST_VBLANK && blank_cnt == '0)
                frame_cnt_o <= frame_cnt_o + F_ONE;
        end
    end

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen: directed frames plus random
// frames compared cycle by cycle against a frame-level reference model.
module tb_video_stream_gen;

    localparam int PW = 8;
    localparam int CW = 13;
    localparam int PERW = 4;
    localparam int FW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en_i = 1'b0;
    logic [1:0]      pattern_i = '0;
    logic [CW-1:0]   width_i = '0, height_i = '0, hblank_i = '0, vblank_i = '0;
    logic [CW-1:0]   pulse_x_i = '0, pulse_y_i = '0;
    logic [PERW-1:0] de_period_i = '0;
    logic [PW-1:0]   const_i = '0;
    logic            busy_o;
    logic [FW-1:0]   frame_cnt_o;

    video_stream_gen_if #(.PIXEL_WIDTH(PW)) vid();

    video_stream_gen #(
        .PIXEL_WIDTH     (PW),
        .CNT_WIDTH       (CW),
        .PERIOD_WIDTH    (PERW),
        .FRAME_CNT_WIDTH (FW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .pattern_i   (pattern_i),
        .width_i     (width_i),
        .height_i    (height_i),
        .de_period_i (de_period_i),
        .hblank_i    (hblank_i),
        .vblank_i    (vblank_i),
        .pulse_x_i   (pulse_x_i),
        .pulse_y_i   (pulse_y_i),
        .const_i     (const_i),
        .vid         (vid),
        .busy_o      (busy_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          de;
        logic [PW-1:0] dat;
        logic          hs;
        logic          vs;
        logic          busy;
        logic [FW-1:0] fc;
    } cyc_t;

    int            errors = 0;
    int            checks = 0;
    int            ones_seen = 0;
    logic [PW-1:0] last_do = '0;
    logic [FW-1:0] exp_frames = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_pixel(input int pat, input int x, input int y,
                                                 input int px, input int py, input int cv);
        case (pat)
            0:       return PW'(x % 256);
            1:       return PW'((x + y) % 256);
            2:       return (x == px && y == py) ? 8'hFF : 8'h00;
            default: return PW'(cv);
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_de"},   32'(vid.de_o),    32'd0);
        check({tag, "_hs"},   32'(vid.hs_o),    32'd1);
        check({tag, "_vs"},   32'(vid.vs_o),    32'd1);
        check({tag, "_busy"}, 32'(busy_o),      32'd0);
        check({tag, "_do"},   32'(vid.do_o),    32'(last_do));
        check({tag, "_fc"},   32'(frame_cnt_o), 32'(exp_frames));
    endtask

    task automatic scramble_cfg();
        pattern_i   = 2'($urandom);
        width_i     = CW'($urandom_range(1, 50));
        height_i    = CW'($urandom_range(1, 50));
        de_period_i = PERW'($urandom);
        hblank_i    = CW'($urandom_range(0, 20));
        vblank_i    = CW'($urandom_range(0, 20));
        pulse_x_i   = CW'($urandom_range(0, 50));
        pulse_y_i   = CW'($urandom_range(0, 50));
        const_i     = PW'($urandom);
    endtask

    // Runs one frame from IDLE; en_i falls (and config is scrambled) at output cycle 'drop'.
    task automatic run_frame(input string tag, input int pat, input int w, input int h,
                             input int p, input int hb, input int vb, input int px,
                             input int py, input int cv, input int drop);
        cyc_t q[$];
        cyc_t c;
        int   pe = (p == 0) ? 1 : p;
        int   he = (hb == 0) ? 1 : hb;
        int   d;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                for (int s = 0; s < pe; s++) begin
                    c.de = (s == pe - 1);
                    if (c.de) last_do = ref_pixel(pat, x, y, px, py, cv);
                    c.dat = last_do; c.hs = 1'b0; c.vs = 1'b0; c.busy = 1'b1; c.fc = exp_frames;
                    q.push_back(c);
                end
            end
            for (int b = 0; b < ((y == h - 1) ? he + vb : he); b++) begin
                c.de = 1'b0; c.dat = last_do; c.hs = 1'b1; c.vs = (y == h - 1); c.busy = 1'b1;
                c.fc = (y == h - 1) ? exp_frames + 1'b1 : exp_frames;
                q.push_back(c);
            end
        end
        d = (drop >= q.size()) ? q.size() - 1 : drop;

        @(posedge clk); #1;
        pattern_i = 2'(pat); width_i = CW'(w); height_i = CW'(h); de_period_i = PERW'(p);
        hblank_i = CW'(hb); vblank_i = CW'(vb); pulse_x_i = CW'(px); pulse_y_i = CW'(py);
        const_i = PW'(cv); en_i = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < q.size(); i++) begin
            if (i == d) begin
                en_i = 1'b0;
                scramble_cfg();
            end
            @(posedge clk); #1;
            check($sformatf("%s_de@%0d", tag, i),   32'(vid.de_o),    32'(q[i].de));
            check($sformatf("%s_do@%0d", tag, i),   32'(vid.do_o),    32'(q[i].dat));
            check($sformatf("%s_hs@%0d", tag, i),   32'(vid.hs_o),    32'(q[i].hs));
            check($sformatf("%s_vs@%0d", tag, i),   32'(vid.vs_o),    32'(q[i].vs));
            check($sformatf("%s_busy@%0d", tag, i), 32'(busy_o),      32'(q[i].busy));
            check($sformatf("%s_fc@%0d", tag, i),   32'(frame_cnt_o), 32'(q[i].fc));
            if (vid.de_o && vid.do_o == 8'hFF) ones_seen++;
        end
        exp_frames = exp_frames + 1'b1;
        @(posedge clk); #1;
        check_idle({tag, "_after"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle behaviour.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_do", 32'(vid.do_o), 32'd0);
        check_idle("rst");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("idle%0d", i));
        end

        // en_i with zero width must not start a frame.
        width_i = '0; height_i = CW'(3); en_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_idle($sformatf("w0_%0d", i));
        end
        en_i = 1'b0;

        // 4x2 ramp x, continuous de, hblank 3, vblank 5.
        run_frame("rampx", 0, 4, 2, 1, 3, 5, 0, 0, 0, 0);

        // 3x2 ramp x+y, de every other cycle.
        run_frame("rampxy", 1, 3, 2, 2, 2, 1, 0, 0, 0, 0);

        // 25x25 delta pulse at (12,12).
        ones_seen = 0;
        run_frame("delta", 2, 25, 25, 1, 1, 2, 12, 12, 0, 0);
        check("delta_ones", 32'(ones_seen), 32'd1);

        // en_i dropped during line 1 of 4; config scrambled at the same time.
        run_frame("endrop", 3, 5, 4, 1, 2, 3, 0, 0, 8'h5A, 5 + 2 + 2);

        // Asynchronous reset mid-line at x=2.
        @(posedge clk); #1;
        pattern_i = 2'd0; width_i = CW'(6); height_i = CW'(2); de_period_i = PERW'(1);
        hblank_i = CW'(2); vblank_i = CW'(1); en_i = 1'b1;
        @(posedge clk); #1;
        en_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid_do_x2", 32'(vid.do_o), 32'd2);
        check("mid_de_x2", 32'(vid.de_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_frames = '0;
        last_do = '0;
        check("arst_do", 32'(vid.do_o), 32'd0);
        check_idle("arst");
        #3 rst_n = 1'b1;
        run_frame("postrst", 0, 6, 2, 1, 2, 1, 0, 0, 0, 0);

        // Random frames.
        for (int f = 0; f < 8; f++) begin
            run_frame($sformatf("rnd%0d", f), int'($urandom_range(0, 3)),
                      int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 30)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_stream_gen.md
Name: video_stream_gen

Overview:
Synthesisable video source that drives the team's pixel-stream protocol (do_o/de_o/hs_o/vs_o), i.e. the transmitter end of the interface consumed by scaler_h and captured by monitor.
- Generates whole frames with a programmable size, pixel spacing and line/frame blanking, and fills them with selectable test patterns.
- Used as on-chip stimulus for the scaler chain and in hardware self-test, in place of bench-driven BMP stimulus.

Parameters:
PIXEL_WIDTH, 8, bits per pixel on do_o
CNT_WIDTH, 13, width of x/y/blank counters (max line/frame size 8191)
PERIOD_WIDTH, 4, width of de_period
FRAME_CNT_WIDTH, 16, width of frame_cnt_o

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en_i  in  1  run enable; frames start only while high
pattern_i  in  2  0 ramp x, 1 ramp x+y, 2 delta pulse, 3 constant
width_i  in  CNT_WIDTH  active pixels per line
height_i  in  CNT_WIDTH  lines per frame
de_period_i  in  PERIOD_WIDTH  clock cycles per pixel slot (0 treated as 1)
hblank_i  in  CNT_WIDTH  cycles with hs_o high between lines (0 treated as 1)
vblank_i  in  CNT_WIDTH  extra cycles with vs_o high after the last line
pulse_x_i  in  CNT_WIDTH  delta pulse column
pulse_y_i  in  CNT_WIDTH  delta pulse row
const_i  in  PIXEL_WIDTH  value for pattern 3
do_o  out  PIXEL_WIDTH  pixel data, valid when de_o=1
de_o  out  1  pixel valid strobe
hs_o  out  1  high outside active line time
vs_o  out  1  high outside active frame time
busy_o  out  1  high from first line start until frame blanking ends
frame_cnt_o  out  FRAME_CNT_WIDTH  completed frames, wraps

Behaviour:
- Reset values: do_o=0, de_o=0, hs_o=1, vs_o=1, busy_o=0, frame_cnt_o=0. Counters are cleared and the FSM goes to IDLE.
- All outputs are registered. Output levels reflect the state and counters of the previous cycle, so latency is 1 clk.
- FSM states: IDLE, LINE, HBLANK, VBLANK.
- IDLE -> LINE: when en_i=1, width_i!=0 and height_i!=0.
  - All config inputs are captured into shadow registers on this transition.
  - Config changes mid-frame have no effect until the next frame.
- LINE: hs_o=0, vs_o=0.
  - The line has width slots of P=max(de_period,1) cycles each.
  - de_o=1 only on the last cycle of each slot, so P=1 gives continuous de_o and P=2 gives a 0,1 pattern.
  - x increments on each de_o; do_o is valid with de_o and holds its last value otherwise.
- LINE -> HBLANK: after the slot with x=width-1. y increments.
- LINE -> VBLANK: instead of HBLANK when y=height-1.
- HBLANK: hs_o=1, vs_o=0, de_o=0 for max(hblank,1) cycles, then -> LINE.
- VBLANK: hs_o=1, vs_o=1, de_o=0 for max(hblank,1)+vblank cycles.
  - frame_cnt_o increments (wraps) on entry.
  - At the end: -> LINE if en_i=1 (re-capturing config), else -> IDLE.
- busy_o=1 in LINE, HBLANK and VBLANK; busy_o=0 in IDLE.
- en_i deasserted mid-frame: the current frame completes fully and no partial frames are produced.
- Asynchronous reset mid-line: outputs immediately take their reset values. The next frame starts at x=0, y=0.
- Patterns (evaluated on the x,y of the pixel being emitted):
  - ramp x: do=x mod 2^PIXEL_WIDTH
  - ramp x+y: do=(x+y) mod 2^PIXEL_WIDTH
  - delta: do=all-ones when x==pulse_x and y==pulse_y, else 0; a pulse outside the frame gives all zeros
  - constant: do=const
- Counter widths: x and y are CNT_WIDTH bits; the slot counter is PERIOD_WIDTH bits; the blank counter is CNT_WIDTH+1 bits so hblank+vblank cannot overflow.

Decomposition:
- Package video_gen_pkg holds:
  - the typedef enum for FSM states
  - the typedef enum for pattern codes (PAT_RAMP_X, PAT_RAMP_XY, PAT_DELTA, PAT_CONST)
  - localparams for the reset levels of hs/vs
- One sub-module, video_pattern: purely combinational (x, y, shadow config) -> pixel value. The top module registers its output.
- Top module: FSM, counters and output registers.

Test Plan:
- Reset held low -> do_o=0, de_o=0, hs_o=1, vs_o=1, busy_o=0, frame_cnt_o=0; with en_i=0 the outputs stay there for 100 clk.
- width=4, height=2, P=1, hblank=3, vblank=5, ramp x:
  - each line gives 4 consecutive de_o with do_o=0,1,2,3 while hs_o=0
  - 3 clk of hs_o=1 between lines, then 8 clk of hs_o=vs_o=1
  - frame_cnt_o goes 0->1
- P=2, width=3, ramp x+y: de_o follows 0,1,0,1,0,1 per line; line 1 gives do_o=1,2,3.
- 25x25 frame, delta at (12,12): exactly one de_o pixel equals 255, at line 12 / pixel 12; all other pixels are 0. Output matches the captured BMP of the same pulse image.
- en_i dropped at line 1 of 4: the frame completes all 4 lines, then IDLE; frame_cnt_o increments once and busy_o falls after VBLANK. A width_i change mid-frame does not alter the line length.
- rst_n asserted mid-line at x=2: outputs return to reset values within the same cycle (asynchronous). After release, the next frame starts with do_o=0 at x=0.
